// File: rtl/sirv_uart_pkg.sv
// Shared UART definitions: receive state encoding, frame width and idle line level.
// Pure declarations; no latency or backpressure of its own.
package sirv_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam int   BITCNT_W  = $clog2(DATA_BITS);
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sirv_sync_chain.sv
// Flop chain that brings an asynchronous pin into the clock domain.
// Latency STAGES clocks; no backpressure (free-running).
module sirv_sync_chain
  import sirv_uart_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = LINE_IDLE
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sirv_uartrx.sv
// UART receiver: mid-bit sampling, one byte per frame, framing-error flag.
// Pulses one clock after the last stop sample; no backpressure (sink must always accept).
module sirv_uartrx
  import sirv_uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 io_en,
  input  logic                 io_in,
  input  logic [15:0]          io_div,
  input  logic                 io_nstop,
  output logic                 io_out_valid,
  output logic [DATA_BITS-1:0] io_out_bits,
  output logic                 io_frm_err
);

  logic rx_s;
  logic tick;

  uart_state_e          state_q,   state_d;
  logic [15:0]          presc_q,   presc_d;
  logic [BITCNT_W-1:0]  bitcnt_q,  bitcnt_d;
  logic [DATA_BITS-1:0] shifter_q, shifter_d;
  logic                 stoprem_q, stoprem_d;
  logic                 valid_q,   valid_d;
  logic                 err_q,     err_d;
  logic [DATA_BITS-1:0] bits_q,    bits_d;

  sirv_sync_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (LINE_IDLE)
  ) u_sync (
    .clock (clock),
    .rst_n (rst_n),
    .d     (io_in),
    .q     (rx_s)
  );

  assign tick = (presc_q == 16'd0);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    bitcnt_d  = bitcnt_q;
    shifter_d = shifter_q;
    stoprem_d = stoprem_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    bits_d    = bits_q;

    if (!io_en) begin
      state_d = IDLE;
      presc_d = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_s != LINE_IDLE) begin
            // With a one-clock bit the edge cycle itself is the start sample.
            if (io_div == 16'd0) begin
              state_d  = DATA;
              presc_d  = 16'd0;
              bitcnt_d = '0;
            end else begin
              state_d = START;
              presc_d = io_div >> 1;
            end
          end
        end
        START: begin
          if (tick) begin
            if (rx_s != LINE_IDLE) begin
              state_d  = DATA;
              presc_d  = io_div;
              bitcnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            presc_d = presc_q - 16'd1;
          end
        end
        DATA: begin
          if (tick) begin
            shifter_d = {rx_s, shifter_q[DATA_BITS-1:1]};
            presc_d   = io_div;
            bitcnt_d  = bitcnt_q + 1'b1;
            if (bitcnt_q == BITCNT_W'(DATA_BITS - 1)) begin
              state_d   = STOP;
              stoprem_d = io_nstop;
            end
          end else begin
            presc_d = presc_q - 16'd1;
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s == LINE_IDLE) begin
              if (stoprem_q) begin
                stoprem_d = 1'b0;
                presc_d   = io_div;
              end else begin
                valid_d = 1'b1;
                bits_d  = shifter_q;
                state_d = IDLE;
              end
            end else begin
              err_d   = 1'b1;
              state_d = WAIT_HIGH;
            end
          end else begin
            presc_d = presc_q - 16'd1;
          end
        end
        WAIT_HIGH: begin
          // A held-low break must not be decoded as a string of 0x00 frames.
          if (rx_s == LINE_IDLE) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= 16'd0;
      bitcnt_q  <= '0;
      shifter_q <= '0;
      stoprem_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      bits_q    <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      bitcnt_q  <= bitcnt_d;
      shifter_q <= shifter_d;
      stoprem_q <= stoprem_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      bits_q    <= bits_d;
    end
  end

  assign io_out_valid = valid_q;
  assign io_frm_err   = err_q;
  assign io_out_bits  = bits_q;

endmodule

// File: tb/tb_sirv_uartrx.sv
// Bench for sirv_uartrx: a serial-frame driver plus a frame-level expectation model.
// Directed scenarios followed by randomized frames of varying divisor, stop count and corruption.
module tb_sirv_uartrx;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        io_en;
  logic        io_in;
  logic [15:0] io_div;
  logic        io_nstop;
  logic        io_out_valid;
  logic [7:0]  io_out_bits;
  logic        io_frm_err;

  always #5 clock = ~clock;

  sirv_uartrx #(.SYNC_STAGES(2)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .io_en        (io_en),
    .io_in        (io_in),
    .io_div       (io_div),
    .io_nstop     (io_nstop),
    .io_out_valid (io_out_valid),
    .io_out_bits  (io_out_bits),
    .io_frm_err   (io_frm_err)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         err_seen  = 0;
  int         exp_err   = 0;
  int         both_seen = 0;
  int         hold_viol = 0;
  logic [7:0] last_bits = 8'h00;
  logic [7:0] exp_last  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (rst_n) begin
      if (io_out_valid) begin
        rx_q.push_back(io_out_bits);
        last_bits <= io_out_bits;
      end else if (io_out_bits !== last_bits) begin
        hold_viol++;
      end
      if (io_frm_err) err_seen++;
      if (io_out_valid && io_frm_err) both_seen++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    io_in = b;
    wait_clks(int'(io_div) + 1);
  endtask

  task automatic idle_bits(input int nbits);
    io_in = 1'b1;
    wait_clks(nbits * (int'(io_div) + 1) + 4);
  endtask

  // Drives one frame; the model records what a correct receiver must report.
  task automatic send_frame(input logic [7:0] d, input logic s1, input logic s2, input int abort_at);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_at) io_en = 1'b0;
      send_bit(d[i]);
    end
    send_bit(s1);
    if (io_nstop) send_bit(s2);
    io_in = 1'b1;
    if (abort_at < 0) begin
      if (s1 && (!io_nstop || s2)) begin
        exp_q.push_back(d);
        exp_last = d;
      end else begin
        exp_err++;
      end
    end
  endtask

  task automatic verify(input string tag);
    int n;
    chk({tag, ".count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, ".data"}, rx_q[i], exp_q[i]);
    chk({tag, ".frm_err"}, err_seen, exp_err);
    chk({tag, ".hold"}, hold_viol, 0);
    chk({tag, ".bits"}, io_out_bits, exp_last);
    rx_q.delete();
    exp_q.delete();
    err_seen  = 0;
    exp_err   = 0;
    hold_viol = 0;
  endtask

  initial begin
    logic [7:0] lb_bytes [4];
    logic [7:0] d;
    logic       s1, s2, bad;
    int         sel;

    lb_bytes[0] = 8'h00;
    lb_bytes[1] = 8'hFF;
    lb_bytes[2] = 8'h55;
    lb_bytes[3] = 8'hAA;

    rst_n    = 1'b0;
    io_en    = 1'b1;
    io_in    = 1'b1;
    io_div   = 16'd3;
    io_nstop = 1'b0;
    wait_clks(3);
    @(negedge clock);
    chk("rst.valid", io_out_valid, 1'b0);
    chk("rst.err", io_frm_err, 1'b0);
    chk("rst.bits", io_out_bits, 8'h00);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    wait_clks(4);

    // Plain frame.
    io_div = 16'd3;
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    idle_bits(3);
    verify("t1");

    // Short glitch must be rejected as a false start.
    io_div = 16'd7;
    io_in  = 1'b0;
    wait_clks(2);
    idle_bits(3);
    verify("t2.glitch");
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    idle_bits(3);
    verify("t2");

    // Bad stop, then a long break, then recovery.
    io_div = 16'd3;
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    io_in = 1'b0;
    wait_clks(40);
    idle_bits(2);
    verify("t3.break");
    send_frame(8'h11, 1'b1, 1'b1, -1);
    idle_bits(3);
    verify("t3");

    // Two stop bits: second one low, then both high.
    io_nstop = 1'b1;
    io_div   = 16'd5;
    send_frame(8'hC3, 1'b1, 1'b0, -1);
    idle_bits(3);
    send_frame(8'hC3, 1'b1, 1'b1, -1);
    idle_bits(3);
    verify("t4");

    // Enable dropped mid-frame.
    io_nstop = 1'b0;
    io_div   = 16'd3;
    send_frame(8'hFF, 1'b1, 1'b1, 3);
    idle_bits(2);
    io_en = 1'b1;
    idle_bits(2);
    send_frame(8'h81, 1'b1, 1'b1, -1);
    idle_bits(3);
    verify("t5");

    // Back-to-back frames at the extreme divisors.
    for (int k = 0; k < 2; k++) begin
      io_div = (k == 0) ? 16'd0 : 16'd15;
      for (int i = 0; i < 4; i++) send_frame(lb_bytes[i], 1'b1, 1'b1, -1);
      idle_bits(3);
      verify((k == 0) ? "t6.div0" : "t6.div15");
    end

    // Random frames: divisor, stop count, data, occasional corrupted stop, random gaps.
    for (int f = 0; f < 40; f++) begin
      io_div   = 16'($urandom_range(0, 12));
      io_nstop = 1'($urandom_range(0, 1));
      d        = 8'($urandom);
      bad      = ($urandom_range(0, 7) == 0);
      s1 = 1'b1;
      s2 = 1'b1;
      if (bad) begin
        sel = io_nstop ? $urandom_range(0, 2) : 0;
        if (sel != 1) s1 = 1'b0;
        if (sel != 0) s2 = 1'b0;
      end
      send_frame(d, s1, s2, -1);
      sel = $urandom_range(0, 2);
      if (bad && sel == 0) sel = 1;
      if (sel != 0) begin
        io_in = 1'b1;
        wait_clks(sel * (int'(io_div) + 1));
      end
    end
    idle_bits(4);
    verify("rand");

    chk("valid_and_err", both_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
